// File: rtl/serial_link_pkg.sv
// Shared types and defaults for the serial link sink blocks.
// Assembler state encoding and the default word width live here.
package serial_link_pkg;

  localparam int WORD_WIDTH = 5;

  typedef enum logic {
    IDLE,
    SHIFT
  } asm_state_t;

endpackage

// File: rtl/word_fifo.sv
// Small circular-buffer FIFO with read/write pointers and an occupancy count.
// The head word is read straight from storage, so it holds while nothing pops.
module word_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer only lands when a pop frees the slot in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_word_assembler.sv
// Collects MSB-first serial bits into words under a frame-start marker and
// queues completed words for a valid/ready consumer; flags framing errors and drops.
module serial_word_assembler
  import serial_link_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             frame_err,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  asm_state_t       state;
  asm_state_t       next_state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] next_word;
  logic             shift_en;
  logic             restart;
  logic             push;
  logic             err;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign next_word  = {sr[WIDTH-2:0], bit_in};
  assign word_valid = ~fifo_empty;
  assign pop        = ~fifo_empty & word_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bit_valid && frame_start) next_state = SHIFT;
      SHIFT:   if (bit_valid && !frame_start && cnt == LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A frame_start bit always restarts; in SHIFT it also abandons the partial word.
  always_comb begin
    shift_en = 1'b0;
    restart  = 1'b0;
    push     = 1'b0;
    err      = 1'b0;
    if (bit_valid) begin
      restart = frame_start;
      case (state)
        IDLE: begin
          shift_en = frame_start;
          err      = ~frame_start;
        end
        SHIFT: begin
          shift_en = 1'b1;
          err      = frame_start;
          push     = ~frame_start & (cnt == LAST);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      if (shift_en) sr <= next_word;
      if (restart)       cnt <= CNT_W'(1);
      else if (push)     cnt <= '0;
      else if (shift_en) cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= err;
      if (push && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  word_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (next_word),
    .dout (word_out),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule
